// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer and its column transform.
package aes_pkg;
  localparam int REG_SIZE = 32;
  localparam int VEC_SIZE = 4;
  localparam int NR       = 10;

  typedef logic [3:0][31:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    KEY,
    SUB,
    MIX
  } aes_seq_e;

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_round_sequencer_if.sv
// Bundle between the round sequencer, instruction issue, the key store and the SubBytes unit.
interface aes_round_sequencer_if;
  import aes_pkg::*;

  logic      start;
  logic      abort;
  state_t    plaintext;
  // Key fetch: key_req stays high with key_idx frozen until a cycle in which
  // key_valid is high; that cycle consumes round_key. key_valid without key_req is ignored.
  logic      key_req;
  logic [3:0] key_idx;
  logic      key_valid;
  state_t    round_key;
  state_t    sb_in;
  state_t    sb_out;
  logic      busy;
  logic      done;
  state_t    result;
  aes_seq_e  dbg_state;

  modport master (
    input  start, abort, plaintext, key_valid, round_key, sb_out,
    output key_req, key_idx, sb_in, busy, done, result, dbg_state
  );

  modport slave (
    output start, abort, plaintext, key_valid, round_key, sb_out,
    input  key_req, key_idx, sb_in, busy, done, result, dbg_state
  );
endinterface

// File: rtl/mix_columns.sv
// AES MixColumns: each column is multiplied by the fixed circulant {02,03,01,01}.
module mix_columns
  import aes_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] din,
  output logic [vecSize-1:0][regSize-1:0] dout
);
  for (genvar c = 0; c < vecSize; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[c][31:24];
    assign a1 = din[c][23:16];
    assign a2 = din[c][15:8];
    assign a3 = din[c][7:0];
    // 3*x is written as xtime(x) ^ x.
    assign dout[c] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  end
endmodule

// File: rtl/aes_round_sequencer.sv
// Multi-cycle AES-128 encryption controller: owns the state register and round counter,
// fetches round keys and steps ARK0, nine full rounds and a final round without MixColumns.
module aes_round_sequencer
  import aes_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  aes_round_sequencer_if.master bus
);
  aes_seq_e   fsm;
  logic [3:0] round;
  state_t     state;
  state_t     mixed;
  state_t     result_q;
  logic       done_q;
  logic       key_req_q;
  logic [3:0] key_idx_q;

  mix_columns #(
    .regSize(REG_SIZE),
    .vecSize(VEC_SIZE)
  ) u_mix (
    .din (state),
    .dout(mixed)
  );

  assign bus.sb_in     = state;
  assign bus.busy      = (fsm != IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.key_req   = key_req_q;
  assign bus.key_idx   = key_idx_q;
  assign bus.dbg_state = fsm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      round     <= 4'd0;
      state     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      key_req_q <= 1'b0;
      key_idx_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      // Abort wins over everything and leaves the datapath registers untouched.
      if (bus.abort) begin
        fsm       <= IDLE;
        key_req_q <= 1'b0;
        key_idx_q <= 4'd0;
      end else begin
        case (fsm)
          IDLE: begin
            if (bus.start) begin
              state     <= bus.plaintext;
              round     <= 4'd0;
              fsm       <= KEY;
              key_req_q <= 1'b1;
              key_idx_q <= 4'd0;
            end
          end
          KEY: begin
            if (bus.key_valid) begin
              state     <= state ^ bus.round_key;
              key_req_q <= 1'b0;
              key_idx_q <= 4'd0;
              if (round == 4'(NR)) begin
                result_q <= state ^ bus.round_key;
                done_q   <= 1'b1;
                fsm      <= IDLE;
              end else begin
                round <= round + 4'd1;
                fsm   <= SUB;
              end
            end
          end
          SUB: begin
            state <= bus.sb_out;
            // The final round goes straight to its key addition.
            if (round < 4'(NR)) begin
              fsm <= MIX;
            end else begin
              fsm       <= KEY;
              key_req_q <= 1'b1;
              key_idx_q <= round;
            end
          end
          MIX: begin
            state     <= mixed;
            fsm       <= KEY;
            key_req_q <= 1'b1;
            key_idx_q <= round;
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: byte-level AES reference model, key store responder,
// external SubBytes+ShiftRows model and a queue-based scoreboard monitor.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_sequencer_if bus();

  aes_round_sequencer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [127:0] exp_sb_q[$];
  logic [3:0]   exp_idx_q[$];
  logic [127:0] last_exp_result = '0;
  logic [7:0]   sbox[256];
  state_t       rk_tbl[11];
  int           wait_cfg[11];
  bit           noise = 1'b0;

  state_t fips_pt, fips_key, fips_ct;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] a;
    p = '0;
    a = a_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} >> (8 - n);
    return d[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] gb(input state_t s, input int c, input int r);
    return s[c][31-8*r -: 8];
  endfunction

  function automatic state_t sub_shift(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][31-8*r -: 8] = sbox[gb(s, (c + r) % 4, r)];
    return o;
  endfunction

  function automatic state_t mix_model(input state_t s);
    state_t o;
    logic [7:0] a[4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = gb(s, c, r);
      for (int r = 0; r < 4; r++)
        o[c][31-8*r -: 8] = gf_mul(a[r], 8'h02) ^ gf_mul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  task automatic expand_key(input state_t key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[i];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      for (int c = 0; c < 4; c++) rk_tbl[r][c] = w[4*r+c];
  endtask

  // Loads the key store and plaintext, and queues every expected observation of one run.
  task automatic prepare(input state_t pt, input state_t key, input bit fips);
    state_t s;
    expand_key(key);
    bus.plaintext = pt;
    s = pt ^ rk_tbl[0];
    for (int i = 0; i <= 10; i++) exp_idx_q.push_back(4'(i));
    for (int r = 1; r <= 10; r++) begin
      exp_sb_q.push_back(s);
      s = sub_shift(s);
      if (r < 10) s = mix_model(s);
      s ^= rk_tbl[r];
    end
    exp_q.push_back(fips ? fips_ct : s);
  endtask

  task automatic flush();
    exp_q.delete();
    exp_cyc_q.delete();
    exp_sb_q.delete();
    exp_idx_q.delete();
  endtask

  // ---------------- environment models ----------------
  always_comb bus.sb_out = sub_shift(bus.sb_in);

  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.key_valid = 1'b0;
    bus.round_key = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.key_req) begin
        if (wait_cnt < wait_cfg[bus.key_idx]) begin
          wait_cnt++;
          bus.key_valid = 1'b0;
          bus.round_key = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          bus.key_valid = 1'b1;
          bus.round_key = rk_tbl[bus.key_idx];
        end
      end else begin
        wait_cnt = 0;
        bus.key_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.round_key = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dbg_state == SUB) begin
        if (exp_sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_in: SUB cycle with no expected state, sb_in %h", bus.sb_in);
        end else check("sb_in", bus.sb_in, exp_sb_q.pop_front());
      end
      if (bus.key_req && bus.key_valid && !bus.abort) begin
        if (exp_idx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL key_idx: unexpected key accept, key_idx %0d", bus.key_idx);
        end else check("key_idx", bus.key_idx, exp_idx_q.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0 || exp_cyc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done: spurious done, result %h", bus.result);
        end else begin
          last_exp_result = exp_q.pop_front();
          check("result", bus.result, last_exp_result);
          check("done_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; start is sampled at the following edge.
  task automatic launch(input int hold);
    int lat;
    lat = 30;
    for (int i = 0; i <= 10; i++) lat += wait_cfg[i];
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    exp_cyc_q.push_back(cyc + lat);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!bus.done && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (!bus.done) begin
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, k);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input aes_seq_e st, input int count, input string name);
    int seen;
    int k;
    seen = 0;
    k = 0;
    while (seen < count && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.dbg_state == st) seen++;
    end
    n_checks++;
    if (seen < count) begin
      n_fail++;
      $display("FAIL %s: state seen %0d times, want %0d", name, seen, count);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_key_req"}, bus.key_req, 1'b0);
    check({tag, "_key_idx"}, bus.key_idx, 4'd0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_result"}, bus.result, '0);
    check({tag, "_sb_in"}, bus.sb_in, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    state_t pt, key;
    fips_pt  = {32'he0370734, 32'h313198a2, 32'h885a308d, 32'h3243f6a8};
    fips_key = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    fips_ct  = {32'h196a0b32, 32'hdc118597, 32'h02dc09fb, 32'h3925841d};
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.plaintext = '0;
    for (int i = 0; i <= 10; i++) wait_cfg[i] = 0;
    build_sbox();

    step(3);
    check_idle_zero("reset");
    rst_n = 1'b1;
    step(2);

    // FIPS-197 vector, zero-wait keys.
    prepare(fips_pt, fips_key, 1'b1);
    launch(0);
    wait_done("fips_zero_wait");
    step(3);

    // Same vector with key-store stalls.
    wait_cfg[5] = 3;
    wait_cfg[10] = 1;
    prepare(fips_pt, fips_key, 1'b1);
    launch(0);
    wait_done("fips_waits");
    wait_cfg[5] = 0;
    wait_cfg[10] = 0;
    step(2);

    // Back-to-back: second start in the done cycle.
    prepare(fips_pt, fips_key, 1'b1);
    launch(0);
    wait_done("b2b_first");
    pt = {$urandom, $urandom, $urandom, $urandom};
    prepare(pt, fips_key, 1'b0);
    launch(0);
    wait_done("b2b_second");
    step(2);

    // start held high through a run yields exactly one done.
    d0 = done_cnt;
    pt = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    prepare(pt, key, 1'b0);
    launch(20);
    wait_done("held_start");
    step(40);
    check("held_start_done_count", 128'(done_cnt), 128'(d0 + 1));

    // Abort in the MIX cycle of round 4.
    d0 = done_cnt;
    prepare(fips_pt, fips_key, 1'b1);
    launch(0);
    wait_state(MIX, 4, "abort_find_mix4");
    check("abort_in_mix", bus.dbg_state, MIX);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    flush();
    check("abort_busy", bus.busy, 1'b0);
    check("abort_state", bus.dbg_state, IDLE);
    check("abort_done", bus.done, 1'b0);
    check("abort_result", bus.result, last_exp_result);
    step(35);
    check("abort_no_done", 128'(done_cnt), 128'(d0));
    prepare(fips_pt, fips_key, 1'b1);
    launch(0);
    wait_done("after_abort");
    step(2);

    // key_valid noise while idle has no effect.
    noise = 1'b1;
    step(20);
    check("noise_idle_state", bus.dbg_state, IDLE);
    check("noise_idle_key_req", bus.key_req, 1'b0);
    check("noise_idle_result", bus.result, last_exp_result);

    // Randomized runs with key-store stalls and key_valid noise outside KEY.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i <= 10; i++) wait_cfg[i] = $urandom_range(0, 2);
      pt = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      prepare(pt, key, 1'b0);
      launch(0);
      wait_done("random_run");
      step($urandom_range(0, 3));
    end
    for (int i = 0; i <= 10; i++) wait_cfg[i] = 0;
    noise = 1'b0;
    step(2);

    // Asynchronous reset in round 7.
    prepare(fips_pt, fips_key, 1'b1);
    launch(0);
    wait_state(SUB, 7, "reset_find_sub7");
    rst_n = 1'b0;
    #1;
    check_idle_zero("midreset");
    flush();
    last_exp_result = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    check("post_reset_state", bus.dbg_state, IDLE);
    prepare(fips_pt, fips_key, 1'b1);
    launch(0);
    wait_done("after_reset");
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Multi-cycle controller that runs one full AES-128 block encryption on the execute-stage datapath: ARK0, nine full rounds, then a final round without MixColumns. It owns the 128-bit state register and the round counter. It fetches round keys from the key store over a req/valid handshake, drives the external combinational SubBytes+ShiftRows unit, and instantiates `mix_columns` for the column transform. It sits between instruction issue (start/done) and the AES datapath units.

## Interface
- `regSize`, 32, bits per column word.
- `vecSize`, 4, columns per state.
- `NR`, 10, number of rounds.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request to encrypt `plaintext`. Sampled only in IDLE.
- `abort` in 1: synchronous cancel. Returns to IDLE and suppresses `done`.
- `plaintext` in [vecSize-1:0][regSize-1:0]: column i is `plaintext[i]`; byte 0 of the column is in [31:24].
- `key_req` out 1: high while waiting for a round key.
- `key_idx` out 4: round index of the requested key, 0..NR.
- `key_valid` in 1: `round_key` is valid this cycle. Ignored unless `key_req` is high.
- `round_key` in [vecSize-1:0][regSize-1:0]: round key, same layout as `plaintext`.
- `sb_in` out [vecSize-1:0][regSize-1:0]: current state, fed to the SubBytes+ShiftRows unit.
- `sb_out` in [vecSize-1:0][regSize-1:0]: same-cycle combinational result of that unit.
- `busy` out 1: FSM is not in IDLE.
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle.
- `result` out [vecSize-1:0][regSize-1:0]: ciphertext. Held until the next `done`.

## Operation
- FSM states: IDLE, KEY, SUB, MIX.
- IDLE
  - `start`=1: latch `plaintext` into `state`, set `round`=0, go to KEY.
- KEY
  - `key_req`=1, `key_idx`=`round`. Stays in KEY while `key_valid`=0.
  - On `key_valid`: `state` <= `state ^ round_key` (XOR over all 128 bits).
  - If `round`==NR: `result` <= new state, `done` <= 1, go to IDLE.
  - Otherwise: `round` <= `round`+1, go to SUB.
- SUB
  - `state` <= `sb_out`.
  - Go to MIX if `round` < NR, else go to KEY (final round skips MixColumns).
- MIX
  - `state` <= `mix_columns(state)`, go to KEY.
- `sb_in` equals `state` at all times.
- `abort` has priority over every transition in every state. Next state is IDLE; `round`, `state`, `result` and `done` are not updated by that edge.
- `start` while `busy` is ignored. `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE.
- `key_valid` outside KEY is ignored and has no side effects.

## Timing
- Reset (`rst_n`=0, asynchronous): FSM=IDLE, `round`=0, `state`=0, `result`=0, `done`=0, `busy`=0, `key_req`=0, `key_idx`=0.
- Zero-wait keys (`key_valid` high in the first KEY cycle of each round):
  - `done` is high exactly 30 cycles after the cycle in which `start` was sampled.
  - Breakdown: 1 for ARK0, 9×3 for rounds 1-9, 2 for round 10.
- Each extra cycle of `key_valid`=0 while in KEY adds exactly one cycle of latency.
- `key_req` and `key_idx` are registered FSM decodes. Their value is stable for the whole KEY dwell.
- `done` is a registered pulse, exactly one cycle wide.
- Reset asserted mid-operation: outputs go to their reset values immediately, with no `done`.

## Structure
- Package `aes_pkg`:
  - `state_t` = logic [3:0][31:0].
  - `localparam NR = 10`.
  - FSM enum `aes_seq_e` {IDLE, KEY, SUB, MIX}.
- One sub-module instance: the existing `mix_columns` (regSize=32, vecSize=4), driven from `state`.
- SubBytes/ShiftRows stays external to this block.

## Test plan
- FIPS-197 App. B, zero-wait keys:
  - Plaintext columns 3243f6a8, 885a308d, 313198a2, e0370734.
  - Key 2b7e1516…09cf4f3c, round keys from the bench model.
  - Required: `result` 3925841d, 02dc09fb, dc118597, 196a0b32; `done` 30 cycles after `start`; `key_idx` sequence 0..10.
- Same vector with 3 wait cycles on `key_idx`=5 and 1 wait cycle on `key_idx`=10 -> same `result`, `done` at cycle 34.
- `start` pulsed every cycle during a run -> exactly one `done`. Back-to-back `start` in the `done` cycle -> second run begins and its `done` arrives 30 cycles later.
- `abort` in a MIX cycle of round 4 -> `busy` low next cycle, no `done`, `result` unchanged. A following `start` runs correctly.
- `rst_n` low mid-round 7 -> all outputs 0 asynchronously. After release, FSM is in IDLE and the FIPS vector passes.
- `key_valid` toggled while in SUB/MIX/IDLE -> no state change. `sb_in` always equals the internal state; the bench checks it against the model at every SUB cycle.
